// File: rtl/instr_aligner_if.sv
// Fetch/decode-side signal bundle for instr_aligner.
// The aligner uses the slave modport; the fetch/decode environment uses master.
interface instr_aligner_if;
    logic        s_flush_i;
    logic [30:0] s_flush_addr_i;
    logic        s_fetch_val_i;
    logic [31:0] s_fetch_data_i;
    logic        s_fetch_rdy_o;
    logic        s_instr_val_o;
    logic        s_instr_rdy_i;
    logic [31:0] s_instr_o;
    logic        s_rvc_o;
    logic [30:0] s_pc_o;

    modport master (
        output s_flush_i, s_flush_addr_i, s_fetch_val_i, s_fetch_data_i, s_instr_rdy_i,
        input  s_fetch_rdy_o, s_instr_val_o, s_instr_o, s_rvc_o, s_pc_o
    );

    modport slave (
        input  s_flush_i, s_flush_addr_i, s_fetch_val_i, s_fetch_data_i, s_instr_rdy_i,
        output s_fetch_rdy_o, s_instr_val_o, s_instr_o, s_rvc_o, s_pc_o
    );
endinterface

// File: rtl/instr_aligner.sv
// Realigns word-aligned fetch words into RVC/RV32 instructions with PC tracking and redirect.
// Define ALIGNER_OREG_EN to add a one-cycle registered output stage.
module instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h8000_0000
) (
    input  logic             s_clk_i,
    input  logic             s_rst_i,
    instr_aligner_if.slave   bus
);
    typedef enum logic [2:0] {
        SEL_SKIP,
        SEL_RVC,
        SEL_RV32,
        SEL_BUF_RVC,
        SEL_STRADDLE
    } sel_e;

    logic [15:0] half_q, half_d;
    logic        half_v_q, half_v_d;
    logic        skip_q, skip_d;
    logic [30:0] pc_q, pc_d;

    sel_e        sel;
    logic        sel_val;
    logic [31:0] sel_instr;
    logic        sel_rvc;
    logic        load_en;
    logic        hs;
    logic        fetch_rdy;
    logic [31:0] data;

    assign data = bus.s_fetch_data_i;

    always_comb begin
        if (skip_q)
            sel = SEL_SKIP;
        else if (!half_v_q)
            sel = (data[1:0] == 2'b11) ? SEL_RV32 : SEL_RVC;
        else
            sel = (half_q[1:0] == 2'b11) ? SEL_STRADDLE : SEL_BUF_RVC;
    end

    always_comb begin
        sel_val   = 1'b0;
        sel_instr = 32'h0;
        sel_rvc   = 1'b0;
        case (sel)
            SEL_RVC: begin
                sel_val   = bus.s_fetch_val_i;
                sel_instr = {16'h0, data[15:0]};
                sel_rvc   = 1'b1;
            end
            SEL_RV32: begin
                sel_val   = bus.s_fetch_val_i;
                sel_instr = data;
            end
            SEL_BUF_RVC: begin
                // buffered halfword is a whole instruction, no fetch word needed
                sel_val   = 1'b1;
                sel_instr = {16'h0, half_q};
                sel_rvc   = 1'b1;
            end
            SEL_STRADDLE: begin
                sel_val   = bus.s_fetch_val_i;
                sel_instr = {data[15:0], half_q};
            end
            default: ;
        endcase
        if (bus.s_flush_i)
            sel_val = 1'b0;
    end

    assign hs = sel_val & load_en;

    always_comb begin
        half_d    = half_q;
        half_v_d  = half_v_q;
        skip_d    = skip_q;
        pc_d      = pc_q;
        fetch_rdy = 1'b0;
        if (bus.s_flush_i) begin
            half_v_d = 1'b0;
            pc_d     = bus.s_flush_addr_i;
            skip_d   = bus.s_flush_addr_i[0];
        end else begin
            case (sel)
                SEL_SKIP: if (bus.s_fetch_val_i) begin
                    fetch_rdy = 1'b1;
                    half_d    = data[31:16];
                    half_v_d  = 1'b1;
                    skip_d    = 1'b0;
                end
                SEL_RVC: if (hs) begin
                    fetch_rdy = 1'b1;
                    half_d    = data[31:16];
                    half_v_d  = 1'b1;
                    pc_d      = pc_q + 31'd1;
                end
                SEL_RV32: if (hs) begin
                    fetch_rdy = 1'b1;
                    pc_d      = pc_q + 31'd2;
                end
                SEL_BUF_RVC: if (hs) begin
                    half_v_d  = 1'b0;
                    pc_d      = pc_q + 31'd1;
                end
                SEL_STRADDLE: if (hs) begin
                    fetch_rdy = 1'b1;
                    half_d    = data[31:16];
                    pc_d      = pc_q + 31'd2;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            half_q   <= 16'h0;
            half_v_q <= 1'b0;
            skip_q   <= BOOT_ADDR[1];
            pc_q     <= BOOT_ADDR[31:1];
        end else begin
            half_q   <= half_d;
            half_v_q <= half_v_d;
            skip_q   <= skip_d;
            pc_q     <= pc_d;
        end
    end

    assign bus.s_fetch_rdy_o = fetch_rdy & ~s_rst_i;

`ifdef ALIGNER_OREG_EN
    logic        oreg_val_q, oreg_val_d;
    logic        oreg_rvc_q, oreg_rvc_d;
    logic [31:0] oreg_instr_q, oreg_instr_d;
    logic [30:0] oreg_pc_q, oreg_pc_d;

    // stage accepts a new instruction whenever it is empty or being drained
    assign load_en = ~oreg_val_q | bus.s_instr_rdy_i;

    always_comb begin
        oreg_val_d   = oreg_val_q;
        oreg_rvc_d   = oreg_rvc_q;
        oreg_instr_d = oreg_instr_q;
        oreg_pc_d    = oreg_pc_q;
        if (bus.s_flush_i) begin
            oreg_val_d = 1'b0;
        end else if (load_en) begin
            oreg_val_d   = sel_val;
            oreg_rvc_d   = sel_rvc;
            oreg_instr_d = sel_instr;
            oreg_pc_d    = pc_q;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            oreg_val_q   <= 1'b0;
            oreg_rvc_q   <= 1'b0;
            oreg_instr_q <= 32'h0;
            oreg_pc_q    <= BOOT_ADDR[31:1];
        end else begin
            oreg_val_q   <= oreg_val_d;
            oreg_rvc_q   <= oreg_rvc_d;
            oreg_instr_q <= oreg_instr_d;
            oreg_pc_q    <= oreg_pc_d;
        end
    end

    assign bus.s_instr_val_o = oreg_val_q;
    assign bus.s_instr_o     = oreg_instr_q;
    assign bus.s_rvc_o       = oreg_rvc_q;
    assign bus.s_pc_o        = oreg_pc_q;
`else
    assign load_en = bus.s_instr_rdy_i;

    assign bus.s_instr_val_o = sel_val & ~s_rst_i;
    assign bus.s_instr_o     = s_rst_i ? 32'h0 : sel_instr;
    assign bus.s_rvc_o       = sel_rvc & ~s_rst_i;
    assign bus.s_pc_o        = pc_q;
`endif
endmodule

// File: doc/instr_aligner.md
Name: instr_aligner

Overview:
Fetch-side realignment block that feeds the RVC/RV32 decoders in the ID stage.
- Consumes a stream of word-aligned 32-bit fetch words.
- Produces one instruction per handshake: a 16-bit compressed instruction or a full 32-bit instruction, including 32-bit instructions that straddle two fetch words.
- Tracks the PC of every emitted instruction and supports redirect (flush) to a halfword-aligned target.

Parameters:
BOOT_ADDR  32'h80000000  PC loaded on reset; bit 0 ignored; bit 1 honoured as for a flush.

Ports:
s_clk_i  in  1  clock
s_rst_i  in  1  asynchronous, active-high reset
s_flush_i  in  1  redirect request; discards all buffered state
s_flush_addr_i  in  31  redirect target [31:1]
s_fetch_val_i  in  1  fetch word valid
s_fetch_data_i  in  32  fetch word; halfword 0 in [15:0]
s_fetch_rdy_o  out  1  fetch word consumed this cycle
s_instr_val_o  out  1  instruction valid
s_instr_rdy_i  in  1  decoder accepts instruction
s_instr_o  out  32  instruction; [31:16]=0 when RVC
s_rvc_o  out  1  instruction is compressed (bits[1:0]!=2'b11)
s_pc_o  out  31  PC [31:1] of s_instr_o

Behaviour:
State registers:
- buf[15:0] and buf_v: leftover upper halfword.
- skip: discard lower halfword of the next word.
- pc[31:1]: PC of the next instruction.

Reset (asynchronous):
- buf_v=0, buf=0, pc=BOOT_ADDR[31:1], skip=BOOT_ADDR[1].
- Outputs during reset: s_instr_val_o=0, s_fetch_rdy_o=0, s_instr_o=0, s_rvc_o=0, s_pc_o=BOOT_ADDR[31:1].

Output selection (combinational, zero latency, evaluated each cycle):
- C0, skip=1: if s_fetch_val_i, then s_fetch_rdy_o=1, buf<=data[31:16], buf_v<=1, skip<=0. No instruction is output.
- C1, buf_v=0, skip=0, data[1:0]!=11: val=s_fetch_val_i, instr={16'b0,data[15:0]}, rvc=1. On handshake: fetch_rdy=1, buf<=data[31:16], buf_v<=1, pc+=1 (halfword units).
- C2, buf_v=0, skip=0, data[1:0]==11: val=s_fetch_val_i, instr=data, rvc=0. On handshake: fetch_rdy=1, pc+=2.
- C3, buf_v=1, buf[1:0]!=11: val=1 regardless of fetch, instr={16'b0,buf}. On handshake: buf_v<=0, pc+=1. Fetch word is NOT consumed (fetch_rdy=0).
- C4, buf_v=1, buf[1:0]==11: val=s_fetch_val_i, instr={data[15:0],buf}. On handshake: fetch_rdy=1, buf<=data[31:16], buf_v stays 1, pc+=2.

Handshake rules:
- Handshake = s_instr_val_o & s_instr_rdy_i.
- In C1, C2 and C4, s_fetch_rdy_o = handshake.
- Outputs stay stable while val=1 and rdy=0.
- s_pc_o = pc at all times.

Flush (priority over everything):
- In the flush cycle: s_instr_val_o=0, s_fetch_rdy_o=0, no state update except redirect.
- Next state: buf_v<=0, pc<=s_flush_addr_i, skip<=s_flush_addr_i[1].
- The fetch word present in the flush cycle is ignored; it must be the new target word or later.

Boundary conditions:
- Back-to-back flushes: the last one wins.
- pc wraps modulo 2^31 halfwords.
- A halfword 16'h0000 is passed through as RVC; the decoder flags it illegal.
- Reset asserted mid-straddle drops buf without output.

Optional Feature:
Macro: ALIGNER_OREG_EN.
- Defined:
  - A registered output stage (instr, rvc, pc, val) is inserted after the selection logic; latency is 1 cycle.
  - Stage load enable = ~oreg_val | s_instr_rdy_i, which replaces s_instr_rdy_i in the handshake equations above.
  - Flush and reset clear oreg_val.
  - Full throughput with rdy held at 1.
- Undefined: combinational outputs as specified, latency 0.

Test Plan:
- Reset with BOOT_ADDR=0x80000000; word 0x45850001 -> out 0x0001 rvc=1 pc=0x80000000, then 0x4585 rvc=1 pc=0x80000002 (second output without fetch_rdy); one fetch consumed.
- Word 0x00000013 -> single out 0x00000013 rvc=0 pc=0x80000000, fetch_rdy=1 same cycle, next pc 0x80000004.
- Straddle: words 0x00130001, 0x45850000 -> 0x0001 @..00; 0x00000013 rvc=0 @..02 (consumes word 2); 0x4585 @..06.
- Flush to 0x80000102, then word 0x12340001 -> no output for that word's low half; out 0x1234 rvc=1 pc=0x80000102.
- Backpressure: s_instr_rdy_i=0 for 3 cycles during C4 -> instr, pc and val stable, fetch_rdy=0; the release cycle completes exactly one handshake.
- Flush asserted while buf_v=1 and val=1 with rdy=1 -> no handshake that cycle; next output comes from the new target; the buffered halfword is never emitted.
